// File: rtl/led_mode_scheduler_pkg.sv
// Shared definitions for the LED mode scheduler: mode encoding, rate indices
// and the mode-advance rule.
package led_mode_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_RATES  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_ALL_ON = 2'd3
    } mode_t;

    // Index of each rate square wave within i_Rate
    localparam int RATE_10HZ = 0;
    localparam int RATE_5HZ  = 1;
    localparam int RATE_2HZ  = 2;
    localparam int RATE_1HZ  = 3;

    // Mode sequence followed on each mode button press
    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_RATES:  nxt = MODE_CHASE;
            MODE_CHASE:  nxt = MODE_ALL_ON;
            MODE_ALL_ON: nxt = MODE_OFF;
            default:     nxt = MODE_RATES;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_mode_scheduler_switch_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-count debouncer and
// a one-cycle pulse on each accepted press (0->1 of the debounced level).
module led_mode_scheduler_switch_debounce #(
    parameter int g_DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Press
);

    localparam int CW = (g_DEBOUNCE_LIMIT > 2) ? $clog2(g_DEBOUNCE_LIMIT) : 1;

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] count_q, count_d;

    // A level must differ from the accepted level for g_DEBOUNCE_LIMIT clocks
    // before it is taken; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        count_d  = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (count_q == CW'(g_DEBOUNCE_LIMIT - 1)) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and press pulse registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            count_q  <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= i_Switch;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            count_q  <= count_d;
            press_q  <= press_d;
        end
    end

    assign o_Press = press_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// Routes the blink generator's rate waves to the four LEDs according to a
// button-driven mode: direct rates, a rate-clocked chase, all on, or all off.
module led_mode_scheduler
    import led_mode_scheduler_pkg::*;
#(
    parameter int g_DEBOUNCE_LIMIT = 250000,
    parameter int g_CHASE_SEL_RST  = RATE_1HZ
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Rate,
    input  logic       i_Mode_Switch,
    input  logic       i_Sel_Switch,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode,
    output logic [1:0] o_Chase_Sel
);

    mode_t       mode_q, mode_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  pos_q, pos_d;
    logic [3:0]  rate_q, rate_dly_q;
    logic [3:0]  led_q, led_d;
    logic        mode_press, sel_press, chase_tick;

    led_mode_scheduler_switch_debounce #(
        .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)
    ) u_mode_db (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Mode_Switch),
        .o_Press  (mode_press)
    );

    led_mode_scheduler_switch_debounce #(
        .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)
    ) u_sel_db (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Sel_Switch),
        .o_Press  (sel_press)
    );

    // Mode state register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            mode_q <= MODE_RATES;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode: advance once per debounced mode press
    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            mode_d = next_mode(mode_q);
        end
    end

    // Select counter and chase position; the tick samples the current select,
    // and a mode press suppresses the tick and zeroes the position on entry.
    always_comb begin
        chase_tick = rate_q[sel_q] & ~rate_dly_q[sel_q];
        sel_d      = sel_press ? sel_q + 2'd1 : sel_q;
        pos_d      = pos_q;
        if (mode_press) begin
            if (mode_d == MODE_CHASE) begin
                pos_d = 2'd0;
            end
        end else if (mode_q == MODE_CHASE && chase_tick) begin
            pos_d = pos_q + 2'd1;
        end
    end

    // LED pattern for the mode in force next cycle, so a mode change shows at once
    always_comb begin
        led_d = 4'b0000;
        case (mode_d)
            MODE_RATES:  led_d = rate_q;
            MODE_CHASE:  led_d = 4'b0001 << pos_d;
            MODE_ALL_ON: led_d = 4'b1111;
            default:     led_d = 4'b0000;
        endcase
    end

    // Rate history, select, chase position and LED output registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            rate_q     <= 4'b0000;
            rate_dly_q <= 4'b0000;
            sel_q      <= 2'(g_CHASE_SEL_RST);
            pos_q      <= 2'd0;
            led_q      <= 4'b0000;
        end else begin
            rate_q     <= i_Rate;
            rate_dly_q <= rate_q;
            sel_q      <= sel_d;
            pos_q      <= pos_d;
            led_q      <= led_d;
        end
    end

    assign o_LED_1     = led_q[0];
    assign o_LED_2     = led_q[1];
    assign o_LED_3     = led_q[2];
    assign o_LED_4     = led_q[3];
    assign o_Mode      = mode_q;
    assign o_Chase_Sel = sel_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with a short debounce limit.
module tb_led_mode_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] rate;
    logic       mode_sw;
    logic       sel_sw;
    logic       led1, led2, led3, led4;
    logic [1:0] mode;
    logic [1:0] csel;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;
    int pos    = 0;

    assign leds = {led4, led3, led2, led1};

    led_mode_scheduler #(
        .g_DEBOUNCE_LIMIT(4),
        .g_CHASE_SEL_RST (3)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Rate        (rate),
        .i_Mode_Switch (mode_sw),
        .i_Sel_Switch  (sel_sw),
        .o_LED_1       (led1),
        .o_LED_2       (led2),
        .o_LED_3       (led3),
        .o_LED_4       (led4),
        .o_Mode        (mode),
        .o_Chase_Sel   (csel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_sw = 1'b1;
        step(10);
        mode_sw = 1'b0;
        step(10);
    endtask

    task automatic press_sel();
        sel_sw = 1'b1;
        step(10);
        sel_sw = 1'b0;
        step(10);
    endtask

    task automatic pulse_rate(input int idx);
        rate[idx] = 1'b0;
        step(4);
        rate[idx] = 1'b1;
        step(4);
    endtask

    task automatic test_reset();
        rst = 1'b1; rate = 4'b0101; mode_sw = 1'b0; sel_sw = 1'b0;
        step(3);
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL reset_leds: got %b expected 0000", leds); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL reset_mode: got %0d expected 1", mode); end
        checks++; if (csel !== 2'd3) begin errors++; $display("FAIL reset_sel: got %0d expected 3", csel); end
        rst = 1'b0;
        step(1);
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL rates_lat1: got %b expected 0000", leds); end
        step(1);
        checks++; if (leds !== 4'b0101) begin errors++; $display("FAIL rates_lat2: got %b expected 0101", leds); end
    endtask

    task automatic test_bounce();
        mode_sw = 1'b1; step(1);
        mode_sw = 1'b0; step(1);
        mode_sw = 1'b1; step(10);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL bounce_mode: got %0d expected 2", mode); end
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL bounce_leds: got %b expected 0001", leds); end
        mode_sw = 1'b0; step(10);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL release_mode: got %0d expected 2", mode); end
        pos = 0;
    endtask

    task automatic test_chase();
        logic [3:0] exp;
        for (int i = 0; i < 5; i++) begin
            rate[3] = 1'b1; step(4);
            pos = (pos + 1) % 4;
            exp = 4'(1 << pos);
            checks++; if (leds !== exp) begin errors++; $display("FAIL chase_rise%0d: got %b expected %b", i, leds, exp); end
            rate[3] = 1'b0; step(4);
            checks++; if (leds !== exp) begin errors++; $display("FAIL chase_fall%0d: got %b expected %b", i, leds, exp); end
        end
    endtask

    task automatic test_select();
        press_sel();
        checks++; if (csel !== 2'd0) begin errors++; $display("FAIL sel_wrap: got %0d expected 0", csel); end
        checks++; if (leds !== 4'b0010) begin errors++; $display("FAIL sel_hold_pos: got %b expected 0010", leds); end
        pulse_rate(0);
        checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL sel0_tick1: got %b expected 0100", leds); end
        rate[3] = 1'b1; step(4);
        checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL sel0_ignore3: got %b expected 0100", leds); end
        rate[3] = 1'b0; step(4);
        pulse_rate(0);
        checks++; if (leds !== 4'b1000) begin errors++; $display("FAIL sel0_tick2: got %b expected 1000", leds); end
        pulse_rate(0);
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL sel0_wrap: got %b expected 0001", leds); end
    endtask

    task automatic test_mode_cycle();
        press_mode();
        checks++; if (mode !== 2'd3 || leds !== 4'b1111) begin errors++; $display("FAIL all_on: got mode %0d leds %b expected 3 1111", mode, leds); end
        press_mode();
        checks++; if (mode !== 2'd0 || leds !== 4'b0000) begin errors++; $display("FAIL off: got mode %0d leds %b expected 0 0000", mode, leds); end
        press_mode();
        checks++; if (mode !== 2'd1 || leds !== 4'b0101) begin errors++; $display("FAIL back_rates: got mode %0d leds %b expected 1 0101", mode, leds); end
        // Press pulse and rising edge of the selected rate land in the same cycle
        rate[0] = 1'b0; step(4);
        mode_sw = 1'b1; step(5);
        rate[0] = 1'b1; step(2);
        checks++; if (mode !== 2'd2 || leds !== 4'b0001) begin errors++; $display("FAIL press_tick: got mode %0d leds %b expected 2 0001", mode, leds); end
        step(8);
        mode_sw = 1'b0; step(10);
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL tick_dropped: got %b expected 0001", leds); end
        press_mode();
        checks++; if (mode !== 2'd3 || leds !== 4'b1111) begin errors++; $display("FAIL all_on2: got mode %0d leds %b expected 3 1111", mode, leds); end
        press_mode();
        checks++; if (mode !== 2'd0 || leds !== 4'b0000) begin errors++; $display("FAIL off2: got mode %0d leds %b expected 0 0000", mode, leds); end
        rate = 4'b1010;
        press_mode();
        checks++; if (mode !== 2'd1 || leds !== 4'b1010) begin errors++; $display("FAIL rates2: got mode %0d leds %b expected 1 1010", mode, leds); end
        rate = 4'b0011; step(1);
        checks++; if (leds !== 4'b1010) begin errors++; $display("FAIL rates2_lat1: got %b expected 1010", leds); end
        step(1);
        checks++; if (leds !== 4'b0011) begin errors++; $display("FAIL rates2_lat2: got %b expected 0011", leds); end
    endtask

    task automatic test_reset_mid();
        press_mode();
        checks++; if (mode !== 2'd2 || leds !== 4'b0001) begin errors++; $display("FAIL chase_entry: got mode %0d leds %b expected 2 0001", mode, leds); end
        pulse_rate(0);
        pulse_rate(0);
        checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL chase_pos2: got %b expected 0100", leds); end
        mode_sw = 1'b1; step(4);
        #2 rst = 1'b1;
        #1;
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL async_leds: got %b expected 0000", leds); end
        checks++; if (mode !== 2'd1 || csel !== 2'd3) begin errors++; $display("FAIL async_state: got mode %0d sel %0d expected 1 3", mode, csel); end
        mode_sw = 1'b0;
        step(3);
        rst = 1'b0;
        step(20);
        checks++; if (mode !== 2'd1 || csel !== 2'd3) begin errors++; $display("FAIL post_reset: got mode %0d sel %0d expected 1 3", mode, csel); end
        checks++; if (leds !== 4'b0011) begin errors++; $display("FAIL post_reset_leds: got %b expected 0011", leds); end
    endtask

    task automatic test_back_to_back();
        mode_sw = 1'b1; sel_sw = 1'b1; step(10);
        mode_sw = 1'b0; sel_sw = 1'b0; step(10);
        checks++; if (mode !== 2'd2 || csel !== 2'd0) begin errors++; $display("FAIL both_press: got mode %0d sel %0d expected 2 0", mode, csel); end
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL both_leds: got %b expected 0001", leds); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_chase();
        test_select();
        test_mode_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
